contador_palabras: RTL and testbench

Word-count block downstream of the transaction layer's four output FIFOs. It watches each output FIFO's pop/empty pair, counts words actually delivered per FIFO plus a running total, and answers idx-addressed read requests from the bench or host with a one-cycle valid pulse. Reads are served only while the transaction-layer FSM reports idle, so every count read reflects a quiescent design.

---
 rtl/capa_pkg.sv | 15 +
 rtl/contador_canal.sv | 34 +++
 rtl/contador_palabras.sv | 110 +++++++++++
 tb/tb_contador_palabras.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/capa_pkg.sv
// Shared constants and read-FSM state type for the word-count block.
package capa_pkg;

  localparam int N_FIFOS   = 4;
  localparam int CNT_W     = 5;
  localparam int IDX_TOTAL = 4;
  localparam int INC_W     = $clog2(N_FIFOS + 1);

  typedef enum logic [1:0] {
    ESPERA,
    LECTURA,
    SOLTAR
  } estado_t;

endpackage

// File: rtl/contador_canal.sv
// One word counter with a variable increment amount.
// Wraps modulo 2^CNT_W by default; saturates at 2^CNT_W-1 when CONTADOR_SAT_EN is defined.
module contador_canal #(
  parameter int CNT_W = capa_pkg::CNT_W,
  parameter int INC_W = capa_pkg::INC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cuenta
);

  logic [CNT_W:0]   suma;
  logic [CNT_W-1:0] cuenta_d;

  // The extra sum bit flags overflow; the increment is never larger than the counter range.
  always_comb begin
    suma = {1'b0, cuenta} + (CNT_W + 1)'(inc);
`ifdef CONTADOR_SAT_EN
    cuenta_d = suma[CNT_W] ? '1 : suma[CNT_W-1:0];
`else
    cuenta_d = suma[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta_d;
    end
  end

endmodule

// File: rtl/contador_palabras.sv
// Per-FIFO and total delivered-word counters with an idle-gated, one-pulse read port.
// Optional macro CONTADOR_SAT_EN makes every counter saturate instead of wrapping.
module contador_palabras #(
  parameter int N_FIFOS = capa_pkg::N_FIFOS,
  parameter int CNT_W   = capa_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FIFOS-1:0] pop_fifo,
  input  logic [N_FIFOS-1:0] fifo_empty,
  input  logic               idle,
  input  logic               req,
  input  logic [2:0]         idx,
  output logic [CNT_W-1:0]   salida_contador,
  output logic               valid_contador
);

  import capa_pkg::estado_t;
  import capa_pkg::ESPERA;
  import capa_pkg::LECTURA;
  import capa_pkg::SOLTAR;
  import capa_pkg::IDX_TOTAL;

  localparam int INC_W = $clog2(N_FIFOS + 1);

  logic [N_FIFOS-1:0] pop_ok;
  logic [INC_W-1:0]   n_pops;
  logic [CNT_W-1:0]   cuentas [0:N_FIFOS];
  logic [CNT_W-1:0]   seleccion;
  logic [CNT_W-1:0]   dato_q;
  logic [CNT_W-1:0]   dato_d;
  logic               lectura_ok;
  estado_t            estado_q;
  estado_t            estado_d;

  // A pop on an empty FIFO delivers no word, so it is not counted.
  assign pop_ok = pop_fifo & ~fifo_empty;

  always_comb begin
    n_pops = '0;
    for (int i = 0; i < N_FIFOS; i++) begin
      n_pops = n_pops + INC_W'(pop_ok[i]);
    end
  end

  for (genvar g = 0; g < N_FIFOS; g++) begin : g_canal
    contador_canal #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .inc    (INC_W'(pop_ok[g])),
      .cuenta (cuentas[g])
    );
  end

  contador_canal #(
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) u_total (
    .clk    (clk),
    .reset  (reset),
    .inc    (n_pops),
    .cuenta (cuentas[N_FIFOS])
  );

  // Registered counter values are captured, so a pop on the capture edge is excluded.
  always_comb begin
    seleccion = '0;
    for (int i = 0; i <= N_FIFOS; i++) begin
      if (idx == 3'(i)) begin
        seleccion = cuentas[i];
      end
    end
  end

  assign lectura_ok = req && idle && (idx <= 3'(IDX_TOTAL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      dato_q   <= '0;
    end else begin
      estado_q <= estado_d;
      dato_q   <= dato_d;
    end
  end

  // SOLTAR holds off a second pulse until the requester drops req.
  always_comb begin
    estado_d = estado_q;
    dato_d   = dato_q;
    case (estado_q)
      ESPERA: begin
        if (lectura_ok) begin
          estado_d = LECTURA;
          dato_d   = seleccion;
        end
      end
      LECTURA: estado_d = req ? SOLTAR : ESPERA;
      SOLTAR:  estado_d = req ? SOLTAR : ESPERA;
      default: estado_d = ESPERA;
    endcase
  end

  assign valid_contador  = (estado_q == LECTURA);
  assign salida_contador = dato_q;

endmodule

// File: tb/tb_contador_palabras.sv
// Randomized self-checking bench for contador_palabras against an arithmetic count model.
module tb_contador_palabras;

  localparam int MAXV = 31;

  logic       clk;
  logic       reset;
  logic [3:0] pop_fifo;
  logic [3:0] fifo_empty;
  logic       idle;
  logic       req;
  logic [2:0] idx;
  logic [4:0] salida_contador;
  logic       valid_contador;

  int checks;
  int passed;
  int mdl [0:4];

  contador_palabras dut (
    .clk             (clk),
    .reset           (reset),
    .pop_fifo        (pop_fifo),
    .fifo_empty      (fifo_empty),
    .idle            (idle),
    .req             (req),
    .idx             (idx),
    .salida_contador (salida_contador),
    .valid_contador  (valid_contador)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int avanza(int v, int n);
`ifdef CONTADOR_SAT_EN
    return (v + n > MAXV) ? MAXV : v + n;
`else
    return (v + n) % (MAXV + 1);
`endif
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Model advances with the inputs held across the coming edge, then time moves to edge+1.
  task automatic step();
    int n;
    n = 0;
    if (reset) begin
      for (int i = 0; i < 5; i++) mdl[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop_fifo[i] && !fifo_empty[i]) begin
          mdl[i] = avanza(mdl[i], 1);
          n++;
        end
      end
      mdl[4] = avanza(mdl[4], n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic [3:0] e);
    pop_fifo   = p;
    fifo_empty = e;
  endtask

  task automatic readCounter(input int sel, input bit rnd, input string tag);
    int exp;
    exp  = mdl[sel];
    req  = 1'b1;
    idx  = 3'(sel);
    idle = 1'b1;
    if (rnd) applyStimulus(4'($urandom), 4'($urandom)); else applyStimulus(4'h0, 4'h0);
    step();
    checkOutput({tag, "_valid"}, valid_contador, 1);
    checkOutput({tag, "_data"}, salida_contador, exp);
    req = 1'b0;
    if (rnd) applyStimulus(4'($urandom), 4'($urandom)); else applyStimulus(4'h0, 4'h0);
    step();
    checkOutput({tag, "_drop"}, valid_contador, 0);
    checkOutput({tag, "_hold"}, salida_contador, exp);
  endtask

  task automatic pulseReset();
    applyStimulus(4'h0, 4'h0);
    req   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int exp;
    checks = 0;
    passed = 0;
    for (int i = 0; i < 5; i++) mdl[i] = 0;

    // Reset held with a pending read request
    reset = 1'b1;
    req   = 1'b1;
    idx   = 3'd0;
    idle  = 1'b1;
    applyStimulus(4'h0, 4'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_valid", valid_contador, 0);
      checkOutput("rst_data", salida_contador, 0);
      step();
    end
    reset = 1'b0;
    step();
    checkOutput("post_rst_valid", valid_contador, 1);
    checkOutput("post_rst_data", salida_contador, 0);
    req = 1'b0;
    step();
    checkOutput("post_rst_drop", valid_contador, 0);

    // 3 / 5 / 2 / 0 pops on FIFOs 0..3
    for (int k = 0; k < 3; k++) begin applyStimulus(4'b0001, 4'h0); step(); end
    for (int k = 0; k < 5; k++) begin applyStimulus(4'b0010, 4'h0); step(); end
    for (int k = 0; k < 2; k++) begin applyStimulus(4'b0100, 4'h0); step(); end
    applyStimulus(4'h0, 4'h0);
    step();
    checkOutput("dir_mdl0", mdl[0], 3);
    checkOutput("dir_mdl4", mdl[4], 10);
    readCounter(0, 0, "dir_c0");
    checkOutput("dir_c0_const", salida_contador, 3);
    readCounter(1, 0, "dir_c1");
    checkOutput("dir_c1_const", salida_contador, 5);
    readCounter(2, 0, "dir_c2");
    checkOutput("dir_c2_const", salida_contador, 2);
    readCounter(3, 0, "dir_c3");
    checkOutput("dir_c3_const", salida_contador, 0);
    readCounter(4, 0, "dir_tot");
    checkOutput("dir_tot_const", salida_contador, 10);

    // Pops on an empty FIFO are ignored
    for (int k = 0; k < 4; k++) begin applyStimulus(4'b0010, 4'b0010); step(); end
    readCounter(1, 0, "empty_c1");
    checkOutput("empty_c1_const", salida_contador, 5);
    readCounter(4, 0, "empty_tot");
    checkOutput("empty_tot_const", salida_contador, 10);

    // Random traffic with random idle, then reads racing random pops
    for (int r = 0; r < 4; r++) begin
      req = 1'b0;
      for (int k = 0; k < 40; k++) begin
        applyStimulus(4'($urandom), 4'($urandom));
        idle = 1'($urandom);
        idx  = 3'($urandom);
        step();
      end
      for (int s = 0; s < 5; s++) readCounter(s, 1, $sformatf("rnd%0d_c%0d", r, s));
    end

    // Read held off while not idle, single pulse once idle rises
    applyStimulus(4'h0, 4'h0);
    req  = 1'b1;
    idx  = 3'd4;
    idle = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("noidle_valid", valid_contador, 0);
    end
    exp  = mdl[4];
    idle = 1'b1;
    step();
    checkOutput("idle_rise_valid", valid_contador, 1);
    checkOutput("idle_rise_data", salida_contador, exp);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("held_req_valid", valid_contador, 0);
    end
    req = 1'b0;
    step();

    // All four FIFOs popping together eight times from zero
    pulseReset();
    for (int k = 0; k < 8; k++) begin applyStimulus(4'hF, 4'h0); step(); end
    applyStimulus(4'h0, 4'h0);
    for (int s = 0; s < 4; s++) begin
      readCounter(s, 0, $sformatf("all_c%0d", s));
      checkOutput("all_const", salida_contador, 8);
    end
    readCounter(4, 0, "all_tot");
`ifdef CONTADOR_SAT_EN
    checkOutput("all_tot_const", salida_contador, 31);
`else
    checkOutput("all_tot_const", salida_contador, 0);
`endif

    // Invalid index is ignored
    req  = 1'b1;
    idx  = 3'd6;
    idle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("bad_idx_valid", valid_contador, 0);
    end
    req = 1'b0;
    step();

    // Reset during LECTURA drops valid at once and clears counters
    req = 1'b1;
    idx = 3'd0;
    step();
    checkOutput("pre_rst_valid", valid_contador, 1);
    req   = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", valid_contador, 0);
    checkOutput("async_rst_data", salida_contador, 0);
    step();
    reset = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      readCounter(s, 0, $sformatf("clr_c%0d", s));
      checkOutput("clr_const", salida_contador, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
